// File: rtl/scope_frame_scheduler.sv
// -----------------------------------------------------------------------------
// scope_frame_scheduler
//   Shares one single-port, two-bank sample RAM between the ADC capture path
//   (writer) and the HDMI pixel path (reader). The display reads the front bank
//   during the active area. Captured samples are buffered in a small FIFO and
//   written to the back bank during blanking. Banks swap on the first vsync
//   rising edge after a complete capture, so the trace never tears.
//
// Optional feature (compile-time macro SCOPE_AUTO_TRIG_EN):
//   When defined, ARMED forces a trigger after AUTO_TIMEOUT clocks ("auto" mode).
//   When undefined, ARMED waits for trig_i indefinitely.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run_i, trig_i       re-arm level, single-cycle trigger
//   adc_valid_i/_data_i/adc_ready_o   ADC sample handshake
//   vsync_i, draw_area_i, counter_x_i video timing from the pixel generator
//   ram_en_o/_we_o/_addr_o/_wdata_o, ram_rdata_i   sample RAM port ({bank,col})
//   pix_sample_o, pix_valid_o         sample for the current column (3 clk latency)
//   state_o                           0 IDLE, 1 ARMED, 2 CAPTURE, 3 PENDING
//   frame_done_o                      one-clock pulse on bank swap
// -----------------------------------------------------------------------------
module scope_frame_scheduler #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AUTO_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              trig_i,
  input  logic              adc_valid_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              adc_ready_o,
  input  logic              vsync_i,
  input  logic              draw_area_i,
  input  logic [ADDR_W-1:0] counter_x_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W:0]   ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] pix_sample_o,
  output logic              pix_valid_o,
  output logic [1:0]        state_o,
  output logic              frame_done_o
);

  localparam int unsigned FA_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FC_W  = FA_W + 1;
  localparam int unsigned ACC_W = $clog2(H_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] COL_END   = ADDR_W'(H_ACTIVE);
  localparam logic [ACC_W-1:0]  ACC_FULL  = ACC_W'(H_ACTIVE);
  localparam logic [FC_W-1:0]   FIFO_FULL = FC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_PENDING = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              front_q, front_d;
  logic              vsync_prev_q;
  logic [FA_W-1:0]   fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [FC_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              last_wr_q, last_wr_d;
  logic              ready_q, ready_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rd_v1_q, rd_v2_q, pix_valid_q;
  logic [DATA_W-1:0] pix_sample_q;
  logic              frame_done_q;

  logic              auto_fire_s, trig_fire_s, accept_s, rd_vis_s, wr_grant_s;
  logic              push_s, start_s, swap_s;
  logic [DATA_W-1:0] fifo_head_s;

  assign fifo_head_s = fifo_mem_q[fifo_rp_q];

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int unsigned AUTO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

  // Auto-trigger timer: counts clocks spent armed, held at zero in every other state
  always_comb begin
    auto_fire_s = (state_q == S_ARMED) && (auto_cnt_q == AUTO_LAST);
    if ((state_q == S_ARMED) && !trig_i && !auto_fire_s) begin
      auto_cnt_d = auto_cnt_q + AUTO_W'(1);
    end else begin
      auto_cnt_d = {AUTO_W{1'b0}};
    end
  end

  // Auto-trigger timer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_q <= {AUTO_W{1'b0}};
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end
`else
  assign auto_fire_s = 1'b0;
`endif

  // Next-state, arbitration, FIFO and pointer logic
  always_comb begin
    trig_fire_s = trig_i | auto_fire_s;
    accept_s    = adc_valid_i & ready_q;
    rd_vis_s    = draw_area_i & (counter_x_i < COL_END);
    // The display always wins the RAM; writes only happen outside the active area
    wr_grant_s  = ~draw_area_i & (fifo_cnt_q != {FC_W{1'b0}});
    state_d     = state_q;
    push_s      = 1'b0;
    start_s     = 1'b0;
    swap_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = run_i ? S_ARMED : S_IDLE;
      end
      S_ARMED: begin
        if (trig_fire_s) begin
          state_d = S_CAPTURE;
          start_s = 1'b1;
          push_s  = accept_s;   // sample in the trigger cycle is the first one kept
        end else begin
          state_d = S_ARMED;
        end
      end
      S_CAPTURE: begin
        push_s  = accept_s;
        // last_wr_q is high while the final write is on the RAM port, so a
        // vsync edge coincident with that write is never seen as a rise here
        state_d = last_wr_q ? S_PENDING : S_CAPTURE;
      end
      S_PENDING: begin
        if (vsync_i && !vsync_prev_q) begin
          swap_s  = 1'b1;
          state_d = run_i ? S_ARMED : S_IDLE;
        end else begin
          state_d = S_PENDING;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    front_d   = swap_s ? ~front_q : front_q;
    fifo_wp_d = push_s ? fifo_wp_q + FA_W'(1) : fifo_wp_q;
    fifo_rp_d = wr_grant_s ? fifo_rp_q + FA_W'(1) : fifo_rp_q;
    case ({push_s, wr_grant_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FC_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FC_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (start_s) begin
      acc_cnt_d = push_s ? ACC_W'(1) : {ACC_W{1'b0}};
      wr_ptr_d  = {ADDR_W{1'b0}};
    end else begin
      acc_cnt_d = push_s ? acc_cnt_q + ACC_W'(1) : acc_cnt_q;
      if (wr_grant_s) begin
        wr_ptr_d = (wr_ptr_q == COL_LAST) ? {ADDR_W{1'b0}} : wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
    last_wr_d = wr_grant_s & (wr_ptr_q == COL_LAST) & (state_q == S_CAPTURE);

    // Ready is registered from next-state values so it always matches the
    // state, accept count and FIFO level that will hold in the next cycle
    case (state_d)
      S_ARMED:   ready_d = 1'b1;
      S_CAPTURE: ready_d = (acc_cnt_d < ACC_FULL) & (fifo_cnt_d != FIFO_FULL);
      default:   ready_d = 1'b0;
    endcase

    ram_en_d = rd_vis_s | wr_grant_s;
    ram_we_d = wr_grant_s;
    if (rd_vis_s) begin
      ram_addr_d  = {front_q, counter_x_i};
      ram_wdata_d = {DATA_W{1'b0}};
    end else if (wr_grant_s) begin
      ram_addr_d  = {~front_q, wr_ptr_q};
      ram_wdata_d = fifo_head_s;
    end else begin
      ram_addr_d  = {(ADDR_W + 1){1'b0}};
      ram_wdata_d = {DATA_W{1'b0}};
    end
  end

  // Capture FIFO storage; validity is defined by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[fifo_wp_q] <= adc_data_i;
    end
  end

  // FSM, pointers, RAM port and pixel pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      front_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      fifo_wp_q    <= {FA_W{1'b0}};
      fifo_rp_q    <= {FA_W{1'b0}};
      fifo_cnt_q   <= {FC_W{1'b0}};
      wr_ptr_q     <= {ADDR_W{1'b0}};
      acc_cnt_q    <= {ACC_W{1'b0}};
      last_wr_q    <= 1'b0;
      ready_q      <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= {(ADDR_W + 1){1'b0}};
      ram_wdata_q  <= {DATA_W{1'b0}};
      rd_v1_q      <= 1'b0;
      rd_v2_q      <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_sample_q <= {DATA_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      vsync_prev_q <= vsync_i;
      fifo_wp_q    <= fifo_wp_d;
      fifo_rp_q    <= fifo_rp_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      acc_cnt_q    <= acc_cnt_d;
      last_wr_q    <= last_wr_d;
      ready_q      <= ready_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_v1_q      <= rd_vis_s;
      rd_v2_q      <= rd_v1_q;
      pix_valid_q  <= rd_v2_q;
      pix_sample_q <= ram_rdata_i;
      frame_done_q <= swap_s;
    end
  end

  assign adc_ready_o  = ready_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign pix_sample_o = pix_sample_q;
  assign pix_valid_o  = pix_valid_q;
  assign state_o      = state_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_scope_frame_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for scope_frame_scheduler. Stimulus pushes expected RAM writes and
// expected pixel samples into queues; a monitor on the falling clock edge pops
// and compares whenever the DUT issues a write or presents a valid pixel.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scope_frame_scheduler;
  localparam int H  = 640;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int TO = 100;

  logic          clk;
  logic          rst_n, run_i, trig_i, adc_valid_i, adc_ready_o;
  logic [DW-1:0] adc_data_i;
  logic          vsync_i, draw_area_i;
  logic [AW-1:0] counter_x_i;
  logic          ram_en_o, ram_we_o;
  logic [AW:0]   ram_addr_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i, pix_sample_o;
  logic          pix_valid_o, frame_done_o;
  logic [1:0]    state_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [AW:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [DW-1:0] exp_pix_q[$];
  wr_t           mon_w;
  logic [DW-1:0] mon_p;
  logic [DW-1:0] ram_mem [2**(AW+1)];
  logic          da_prev;
  int            idx, acc_line0, line, bad;
  logic [1:0]    auto_exp;

  scope_frame_scheduler #(
    .H_ACTIVE(H), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(16), .AUTO_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .trig_i(trig_i),
    .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i), .adc_ready_o(adc_ready_o),
    .vsync_i(vsync_i), .draw_area_i(draw_area_i), .counter_x_i(counter_x_i),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .pix_sample_o(pix_sample_o), .pix_valid_o(pix_valid_o),
    .state_o(state_o), .frame_done_o(frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model: registered read, data one clock after the address
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
      ram_rdata_i <= ram_mem[ram_addr_o];
    end
  end

  // draw_area_i as seen in the cycle a write grant was decided
  always @(posedge clk) da_prev <= draw_area_i;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ram_en_o === 1'b1 && ram_we_o === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", ram_addr_o, ram_wdata_o);
      end else begin
        mon_w = exp_wr_q.pop_front();
        chk("ram_write", {ram_addr_o, ram_wdata_o}, {mon_w.addr, mon_w.data});
      end
      chk("write_in_blank", da_prev, 1'b0);
    end
    if (pix_valid_o === 1'b1) begin
      if (exp_pix_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pixel: got 0x%0h, expected no pixel", pix_sample_o);
      end else begin
        mon_p = exp_pix_q.pop_front();
        chk("pix_sample", pix_sample_o, mon_p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic bank, input int col, input logic [DW-1:0] data);
    exp_wr_q.push_back({bank, AW'(col), data});
  endtask

  // Sweep one active line over the front bank; mode 0 expects col&FF, mode 1 col^A5
  task automatic read_line(input int mode);
    logic [DW-1:0] v;
    for (int c = 0; c < H + 10; c++) begin
      draw_area_i = 1'b1;
      counter_x_i = AW'(c);
      v = DW'(c);
      if (c < H) exp_pix_q.push_back((mode == 1) ? (v ^ 8'hA5) : v);
      tick();
    end
    draw_area_i = 1'b0;
    counter_x_i = '0;
    repeat (5) tick();
  endtask

  // Raise vsync from PENDING and check one frame_done pulse and the next state
  task automatic vsync_swap(input logic [1:0] exp_state);
    chk("state_pending", state_o, 2'd3);
    vsync_i = 1'b1;
    chk("frame_done_idle", frame_done_o, 1'b0);
    tick();
    chk("frame_done_pulse", frame_done_o, 1'b1);
    chk("state_after_swap", state_o, exp_state);
    tick();
    chk("frame_done_single", frame_done_o, 1'b0);
    repeat (3) tick();
    vsync_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; run_i = 1'b0; trig_i = 1'b0; adc_valid_i = 1'b0; adc_data_i = '0;
    vsync_i = 1'b0; draw_area_i = 1'b0; counter_x_i = '0;
    #22;
    chk("reset_state", state_o, 2'd0);
    chk("reset_ready", adc_ready_o, 1'b0);
    chk("reset_ram_en", ram_en_o, 1'b0);
    chk("reset_pix_valid", pix_valid_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_hold", state_o, 2'd0);
    run_i = 1'b1;
    tick();
    chk("armed_state", state_o, 2'd1);
    chk("armed_ready", adc_ready_o, 1'b1);

    // Frame 1: sample every 4 clocks, blanking only, into bank 1
    for (int i = 0; i < H; i++) begin
      trig_i = (i == 0);
      adc_valid_i = 1'b1;
      adc_data_i = DW'(i);
      push_wr(1'b1, i, DW'(i));
      tick();
      trig_i = 1'b0;
      adc_valid_i = 1'b0;
      if (i == 0) chk("state_capture", state_o, 2'd2);
      repeat (3) tick();
    end
    chk("frame1_writes_drained", exp_wr_q.size(), 0);
    vsync_swap(2'd1);
    read_line(0);

    // Frame 2: ADC valid every clock across 640-clk active lines, into bank 0
    idx = 0; acc_line0 = 0; line = 0;
    while (idx < H && line < 8) begin
      for (int c = 0; c < 800; c++) begin
        draw_area_i = (c < H);
        counter_x_i = (c < H) ? AW'(c) : '0;
        if (c < H) exp_pix_q.push_back(DW'(c));
        trig_i = (line == 0 && c == 0);
        adc_valid_i = (idx < H);
        adc_data_i = DW'(idx);
        if (adc_valid_i && adc_ready_o) begin
          push_wr(1'b0, idx, DW'(idx));
          idx++;
          if (line == 0 && c < H) acc_line0++;
        end
        tick();
      end
      line++;
    end
    trig_i = 1'b0; adc_valid_i = 1'b0; draw_area_i = 1'b0; counter_x_i = '0;
    repeat (30) tick();
    chk("fifo_backpressure_count", acc_line0, 16);
    chk("frame2_all_accepted", idx, H);
    chk("frame2_writes_drained", exp_wr_q.size(), 0);
    vsync_swap(2'd1);

    // Frame 3: one sample per clock into bank 1, run_i drops mid-capture,
    // last write coincides with a vsync rise
    for (int i = 0; i < H; i++) begin
      trig_i = (i == 0);
      adc_valid_i = 1'b1;
      adc_data_i = DW'(i) ^ 8'hA5;
      push_wr(1'b1, i, DW'(i) ^ 8'hA5);
      run_i = (i < 300);
      tick();
    end
    trig_i = 1'b0;
    adc_valid_i = 1'b0;
    chk("ready_after_full_frame", adc_ready_o, 1'b0);
    tick();
    vsync_i = 1'b1;
    chk("last_write_coincident", {ram_we_o, ram_addr_o}, {1'b1, 1'b1, AW'(H - 1)});
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (state_o !== 2'd3 || frame_done_o !== 1'b0) bad++;
    end
    chk("no_swap_on_coincident_vsync", bad, 0);
    vsync_i = 1'b0;
    repeat (3) tick();
    vsync_swap(2'd0);
    for (int k = 0; k < 3; k++) begin
      trig_i = 1'b1;
      tick();
      trig_i = 1'b0;
      repeat (2) tick();
    end
    chk("idle_ignores_trig", state_o, 2'd0);
    read_line(1);

    // Asynchronous reset in the middle of a capture
    run_i = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      trig_i = (j == 0);
      adc_valid_i = 1'b1;
      adc_data_i = DW'(j);
      draw_area_i = 1'b1;
      counter_x_i = AW'(700);
      tick();
    end
    trig_i = 1'b0;
    chk("state_capture_pre_reset", state_o, 2'd2);
    chk("ready_pre_reset", adc_ready_o, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state_o, 2'd0);
    chk("arst_ready", adc_ready_o, 1'b0);
    chk("arst_ram", {ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}, '0);
    chk("arst_pix", {pix_valid_o, pix_sample_o}, '0);
    chk("arst_frame_done", frame_done_o, 1'b0);
    adc_valid_i = 1'b0; draw_area_i = 1'b0; counter_x_i = '0; run_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ram_en_o !== 1'b0 || state_o !== 2'd0) bad++;
    end
    chk("fifo_empty_after_reset", bad, 0);
    draw_area_i = 1'b1;
    counter_x_i = AW'(5);
    exp_pix_q.push_back(8'd5);
    tick();
    draw_area_i = 1'b0;
    counter_x_i = '0;
    chk("front_bank_after_reset", {ram_en_o, ram_we_o, ram_addr_o}, {1'b1, 1'b0, 1'b0, AW'(5)});
    repeat (5) tick();

    // Auto trigger: no trig_i, ARMED for TO clocks
    run_i = 1'b1;
    tick();
    chk("auto_armed_entry", state_o, 2'd1);
    bad = 0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (state_o !== 2'd1) bad++;
    end
    chk("auto_armed_hold", bad, 0);
    tick();
`ifdef SCOPE_AUTO_TRIG_EN
    auto_exp = 2'd2;
`else
    auto_exp = 2'd1;
`endif
    chk("auto_trigger_at_timeout", state_o, auto_exp);
    repeat (50) tick();
    chk("auto_state_later", state_o, auto_exp);

    chk("write_scoreboard_empty", exp_wr_q.size(), 0);
    chk("pixel_scoreboard_empty", exp_pix_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
